// File: rtl/stream_rr_arbiter_flushable.sv
`default_nettype none
// ============================================================================
//  Module      : stream_rr_arbiter_flushable
//  Description : Round-robin arbiter feeding a flushable two-entry spill
//                stage. NumIn valid/ready requesters share one registered
//                output stream. Each accepted beat is tagged with the index
//                of its source requester. flush_i discards buffered beats and
//                restarts arbitration at requester 0.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        in   1                clock, rising edge
//    rst_i        in   1                asynchronous reset, active-high
//    flush_i      in   1                discard buffered beats, reset RR pointer
//    inp_valid_i  in   NumIn            per-requester valid
//    inp_ready_o  out  NumIn            per-requester ready (one-hot or zero)
//    inp_data_i   in   NumIn*DataWidth  packed payloads, requester k at
//                                       [k*DataWidth +: DataWidth]
//    oup_valid_o  out  1                output valid
//    oup_ready_i  in   1                output ready
//    oup_data_o   out  DataWidth        output payload (head entry)
//    oup_idx_o    out  IdxWidth         source requester of the output beat
//    dropped_o    out  2                entries discarded by flush this cycle
// ============================================================================
module stream_rr_arbiter_flushable #(
  parameter  int unsigned NumIn     = 4,
  parameter  int unsigned DataWidth = 32,
  localparam int unsigned IdxWidth  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [NumIn-1:0]           inp_valid_i,
  output logic [NumIn-1:0]           inp_ready_o,
  input  logic [NumIn*DataWidth-1:0] inp_data_i,
  output logic                       oup_valid_o,
  input  logic                       oup_ready_i,
  output logic [DataWidth-1:0]       oup_data_o,
  output logic [IdxWidth-1:0]        oup_idx_o,
  output logic [1:0]                 dropped_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [IdxWidth:0]   c_num_in   = (IdxWidth+1)'(NumIn);
  localparam logic [IdxWidth-1:0] c_last_idx = IdxWidth'(NumIn - 1);

  // Registered state: occupancy, RR pointer, head entry A, spill entry B.
  state_e                r_state;
  logic [IdxWidth-1:0]   r_rr;
  logic [DataWidth-1:0]  r_a_data;
  logic [IdxWidth-1:0]   r_a_idx;
  logic [DataWidth-1:0]  r_b_data;
  logic [IdxWidth-1:0]   r_b_idx;

  state_e                w_state_next;
  logic [IdxWidth-1:0]   w_rr_next;
  logic                  w_load_a;
  logic                  w_load_b;
  logic                  w_shift;

  logic                  w_grant_found;
  logic [IdxWidth-1:0]   w_grant_idx;
  logic [DataWidth-1:0]  w_grant_data;
  logic                  w_buf_ready;
  logic                  w_acc;
  logic                  w_dq;
  logic [1:0]            w_occ;
  logic [DataWidth-1:0]  w_in_data [NumIn];

  for (genvar gi = 0; gi < NumIn; gi++) begin : g_unpack
    assign w_in_data[gi] = inp_data_i[gi*DataWidth +: DataWidth];
  end

  // Priority scan starting at r_rr and wrapping around.
  always_comb begin
    logic [IdxWidth:0] cand;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    cand          = '0;
    for (int k = 0; k < NumIn; k++) begin
      cand = {1'b0, r_rr} + (IdxWidth+1)'(k);
      if (cand >= c_num_in) begin
        cand = cand - c_num_in;
      end
      if (!w_grant_found && inp_valid_i[cand[IdxWidth-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = cand[IdxWidth-1:0];
      end
    end
  end

  assign w_grant_data = w_in_data[w_grant_idx];

  // Ready depends only on registered occupancy, never on oup_ready_i.
  assign w_buf_ready = (r_state != ST_TWO);
  assign w_acc       = w_grant_found && w_buf_ready && !flush_i;
  assign w_dq        = oup_valid_o && oup_ready_i;

  for (genvar gi = 0; gi < NumIn; gi++) begin : g_ready
    assign inp_ready_o[gi] = w_acc && (w_grant_idx == IdxWidth'(gi));
  end

  always_comb begin
    w_occ = 2'd0;
    case (r_state)
      ST_ONE:  w_occ = 2'd1;
      ST_TWO:  w_occ = 2'd2;
      default: w_occ = 2'd0;
    endcase
  end

  // A head beat handed off during the flush cycle counts as delivered.
  assign dropped_o = flush_i ? (w_occ - {1'b0, w_dq}) : 2'd0;

  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_shift      = 1'b0;
    if (flush_i) begin
      w_state_next = ST_EMPTY;
      w_rr_next    = '0;
    end else begin
      if (w_acc) begin
        w_rr_next = (w_grant_idx == c_last_idx) ? '0
                                                : (w_grant_idx + IdxWidth'(1));
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_next = ST_ONE;
            w_load_a     = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && !w_dq) begin
            w_state_next = ST_TWO;
            w_load_b     = 1'b1;
          end else if (w_acc && w_dq) begin
            // Head leaves and the new beat replaces it in the same cycle.
            w_load_a = 1'b1;
          end else if (w_dq) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_dq) begin
            w_state_next = ST_ONE;
            w_shift      = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_EMPTY;
      r_rr     <= '0;
      r_a_data <= '0;
      r_a_idx  <= '0;
      r_b_data <= '0;
      r_b_idx  <= '0;
    end else begin
      r_state <= w_state_next;
      r_rr    <= w_rr_next;
      if (w_load_a) begin
        r_a_data <= w_grant_data;
        r_a_idx  <= w_grant_idx;
      end else if (w_shift) begin
        r_a_data <= r_b_data;
        r_a_idx  <= r_b_idx;
      end
      if (w_load_b) begin
        r_b_data <= w_grant_data;
        r_b_idx  <= w_grant_idx;
      end
    end
  end

  assign oup_valid_o = (r_state != ST_EMPTY);
  assign oup_data_o  = r_a_data;
  assign oup_idx_o   = r_a_idx;

endmodule
`default_nettype wire
